program_sequencer: RTL and testbench
====================================

# program_sequencer

Instruction sequencer that drives the core's instruction port: fetches a program from an instruction memory and issues one instruction at a time over the `start`/`busy` handshake. Sits between program memory and `core`; replaces the testbench-driven instruction feed with synthesizable control. Reports completion, and optionally an execution cycle count.

## Interface
- `INSTRUCTION_WIDTH`, default `` `INSTRUCTION_WIDTH ``: instruction word width.
- `ADDR_WIDTH`, default 10: program memory address width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: start program execution; sampled only in IDLE.
- `programLength` in ADDR_WIDTH+1: instruction count; sampled with `run`.
- `memAddr` out ADDR_WIDTH: program memory address, equal to current PC.
- `memData` in INSTRUCTION_WIDTH: asynchronous-read memory data for `memAddr`.
- `instructionOut` out INSTRUCTION_WIDTH: connects to core `instructionIn`.
- `start` out 1: instruction valid; connects to core `start`.
- `busy` in 1: core busy; connects to core `busy`.
- `active` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the program has completed.
- `cycleCount` out 32: execution cycles of the last run.

## Operation
- States: IDLE, FETCH, ISSUE, DRAIN, DONE. Encodings are fixed constants.
- IDLE:
  - `run`=1 with `programLength`=0 goes to DONE.
  - `run`=1 otherwise: latch length, PC<=0, go to FETCH.
- FETCH:
  - `memAddr`=PC.
  - On the edge: `instructionOut`<=`memData`, `start`<=1, go to ISSUE.
- ISSUE:
  - `instructionOut` and `start` are held stable.
  - Accept occurs on an edge where `start`=1 and `busy`=0. At accept, PC<=PC+1 and `start`<=0.
  - If PC+1 equals the length, go to DRAIN; otherwise go to FETCH.
  - While `busy`=1, remain in ISSUE.
- DRAIN: wait for `busy`=0, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `run` in any state other than IDLE is ignored. A new length is not sampled mid-run.
- PC width is ADDR_WIDTH+1. The comparison uses the full width, so a length of 2^ADDR_WIDTH is legal.
- `memAddr` is PC truncated to ADDR_WIDTH bits.
- Reset values: state IDLE, PC 0, `instructionOut` 0, `start` 0, `done` 0, `active` 0, `cycleCount` 0.
- Reset mid-run aborts immediately: `start` drops asynchronously and no `done` pulse is produced.

## Timing
- `run` sampled at edge E0. First `start` is high after E1.
- With `busy`=0 throughout, throughput is one instruction per 2 cycles; accepts occur at E2, E4, …, E2N.
- DRAIN is entered at E2N, DONE at E2N+1, and `done` is high for one cycle after E2N+1.
- Each cycle the core holds `busy`=1 in ISSUE or DRAIN adds one cycle.
- `start` is a registered output with no combinational path from `busy`.
- `done`, `active` and `start` are all registered.

## Configuration
- `PROGRAM_SEQUENCER_CYCLE_COUNT_EN` defined:
  - 32-bit counter cleared when `run` is accepted in IDLE.
  - Increments on every edge where the state before the edge is FETCH, ISSUE or DRAIN.
  - Saturates at all-ones.
  - Value is held from DONE until the next accepted `run`.
  - Busy-free result is 2N+1; N=0 gives 0.
- Not defined: `cycleCount` is tied to 0, no counter flops are instantiated, and the port remains present.

## Structure
- State encodings, the default ADDR_WIDTH and the cycle counter width (32) go in `globalVariables.v` alongside `INSTRUCTION_WIDTH`.
- One sub-module: `cycle_counter`, a saturating counter with clear/enable, instantiated only under the macro.
- FSM, PC and the issue register stay in `program_sequencer`.

## Test plan
- Length 3, memory 0x11/0x22/0x33, `busy`=0:
  - `instructionOut` shows 0x11, 0x22, 0x33 with `start` high after E1, E3, E5.
  - `done` pulses after E7; `cycleCount`=7.
- Same program, core holds `busy`=1 for 4 cycles on the second instruction:
  - 0x22 is held stable with `start`=1 until accepted.
  - `done` pulses after E11; `cycleCount`=11.
- `busy` high at the final accept edge, then held 2 more cycles:
  - Sequencer stays in DRAIN.
  - `done` pulses only after `busy` falls; no extra `start`.
- `programLength`=0 with `run`:
  - `done` pulses after E0; `start` never asserts; `cycleCount`=0.
- `run` pulsed mid-program, then `reset` low while in ISSUE:
  - The mid-program `run` has no effect.
  - On `reset`, `start` drops to 0 immediately and all outputs return to their reset values.
  - A subsequent `run` restarts at address 0.
- Build without `PROGRAM_SEQUENCER_CYCLE_COUNT_EN`, rerun the first scenario: identical handshake; `cycleCount` stays 0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared constants and state encoding for the program sequencer.
// Supplies a fallback INSTRUCTION_WIDTH when the global width define is absent.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif

package program_sequencer_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int CYCLE_COUNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Used for execution cycle accounting in program_sequencer.
module cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear wins over enable; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetches a program from instruction memory and issues it to the core over start/busy.
// Define PROGRAM_SEQUENCER_CYCLE_COUNT_EN to enable the execution cycle counter.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif

module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = `INSTRUCTION_WIDTH,
  parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [ADDR_WIDTH:0]          programLength,
  output logic [ADDR_WIDTH-1:0]        memAddr,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic                         start,
  input  logic                         busy,
  output logic                         active,
  output logic                         done,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycleCount
);

  seq_state_t                   state, stateNext;
  logic [ADDR_WIDTH:0]          pc, pcNext, pcInc;
  logic [ADDR_WIDTH:0]          length, lengthNext;
  logic [INSTRUCTION_WIDTH-1:0] instrNext;
  logic                         startNext;

  assign pcInc   = pc + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign memAddr = pc[ADDR_WIDTH-1:0];

  // done and active are derived from the next state so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pc             <= '0;
      length         <= '0;
      instructionOut <= '0;
      start          <= 1'b0;
      done           <= 1'b0;
      active         <= 1'b0;
    end else begin
      state          <= stateNext;
      pc             <= pcNext;
      length         <= lengthNext;
      instructionOut <= instrNext;
      start          <= startNext;
      done           <= (stateNext == DONE);
      active         <= (stateNext != IDLE);
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    lengthNext = length;
    instrNext  = instructionOut;
    startNext  = start;
    case (state)
      IDLE: begin
        if (run) begin
          if (programLength == '0) begin
            stateNext = DONE;
          end else begin
            lengthNext = programLength;
            pcNext     = '0;
            stateNext  = FETCH;
          end
        end
      end
      FETCH: begin
        instrNext = memData;
        startNext = 1'b1;
        stateNext = ISSUE;
      end
      ISSUE: begin
        if (start && !busy) begin
          pcNext    = pcInc;
          startNext = 1'b0;
          stateNext = (pcInc == length) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (!busy) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        startNext = 1'b0;
      end
    endcase
  end

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
  logic countClear, countEnable;

  assign countClear  = (state == IDLE) && run;
  assign countEnable = (state == FETCH) || (state == ISSUE) || (state == DRAIN);

  cycle_counter #(
    .WIDTH(CYCLE_COUNT_WIDTH)
  ) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .clear (countClear),
    .enable(countEnable),
    .count (cycleCount)
  );
`else
  assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with hand-computed expectations.
// Expected cycleCount follows whether PROGRAM_SEQUENCER_CYCLE_COUNT_EN is defined.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif

module tb_program_sequencer;

  localparam int IW = `INSTRUCTION_WIDTH;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [AW:0]   programLength = '0;
  logic [AW-1:0] memAddr;
  logic [IW-1:0] memData;
  logic [IW-1:0] instructionOut;
  logic          start;
  logic          busy = 1'b0;
  logic          active;
  logic          done;
  logic [31:0]   cycleCount;

  logic [IW-1:0] mem [0:(1<<AW)-1];

  int assertCount = 0;
  int failCount   = 0;

  assign memData = mem[memAddr];

  always #5 clk = ~clk;

  program_sequencer #(
    .INSTRUCTION_WIDTH(IW),
    .ADDR_WIDTH       (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .programLength (programLength),
    .memAddr       (memAddr),
    .memData       (memData),
    .instructionOut(instructionOut),
    .start         (start),
    .busy          (busy),
    .active        (active),
    .done          (done),
    .cycleCount    (cycleCount)
  );

  function automatic logic [31:0] expCount(input int n);
`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic runValue, input logic [AW:0] len,
                               input logic busyValue);
    run           = runValue;
    programLength = len;
    busy          = busyValue;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIssue(input string tag, input logic [IW-1:0] instr);
    checkOutput({tag, "_start"}, 32'(start), 32'd1);
    checkOutput({tag, "_instr"}, 32'(instructionOut), 32'(instr));
  endtask

  // Busy-free three-instruction run; E0 is the edge that samples run.
  task automatic runBasic(input string tag);
    applyStimulus(1'b1, 11'd3, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    checkOutput({tag, "_e0_active"}, 32'(active), 32'd1);
    checkOutput({tag, "_e0_start"}, 32'(start), 32'd0);
    step(); checkIssue({tag, "_e1"}, 16'h11);
    step(); checkOutput({tag, "_e2_start"}, 32'(start), 32'd0);
    step(); checkIssue({tag, "_e3"}, 16'h22);
    step();
    step(); checkIssue({tag, "_e5"}, 16'h33);
    step(); checkOutput({tag, "_e6_done"}, 32'(done), 32'd0);
    step();
    checkOutput({tag, "_e7_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_e7_start"}, 32'(start), 32'd0);
    step();
    checkOutput({tag, "_e8_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_e8_active"}, 32'(active), 32'd0);
    checkOutput({tag, "_count"}, cycleCount, expCount(7));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = 16'h11;
    mem[1] = 16'h22;
    mem[2] = 16'h33;

    #2 reset = 1'b0;
    #2;
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_instr", 32'(instructionOut), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_count", cycleCount, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    $display("[TB] basic run, busy low");
    runBasic("basic");

    $display("[TB] busy held four cycles on second instruction");
    applyStimulus(1'b1, 11'd3, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    step(); checkIssue("stall_e1", 16'h11);
    step();
    step(); checkIssue("stall_e3", 16'h22);
    busy = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      step();
      checkIssue($sformatf("stall_e%0d", i), 16'h22);
    end
    busy = 1'b0;
    step(); checkOutput("stall_e8_start", 32'(start), 32'd0);
    step(); checkIssue("stall_e9", 16'h33);
    step(); checkOutput("stall_e10_done", 32'(done), 32'd0);
    step(); checkOutput("stall_e11_done", 32'(done), 32'd1);
    step(); checkOutput("stall_e12_done", 32'(done), 32'd0);
    checkOutput("stall_count", cycleCount, expCount(11));

    $display("[TB] busy held through drain");
    applyStimulus(1'b1, 11'd3, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    for (int i = 1; i <= 6; i++) step();
    busy = 1'b1;
    step();
    checkOutput("drain_e7_done", 32'(done), 32'd0);
    checkOutput("drain_e7_start", 32'(start), 32'd0);
    step();
    checkOutput("drain_e8_done", 32'(done), 32'd0);
    checkOutput("drain_e8_active", 32'(active), 32'd1);
    checkOutput("drain_e8_start", 32'(start), 32'd0);
    busy = 1'b0;
    step(); checkOutput("drain_e9_done", 32'(done), 32'd1);
    step(); checkOutput("drain_e10_done", 32'(done), 32'd0);
    checkOutput("drain_count", cycleCount, expCount(9));

    $display("[TB] zero-length program");
    applyStimulus(1'b1, 11'd0, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_start", 32'(start), 32'd0);
    step();
    checkOutput("zero_done_clr", 32'(done), 32'd0);
    checkOutput("zero_start2", 32'(start), 32'd0);
    checkOutput("zero_count", cycleCount, 32'd0);

    $display("[TB] mid-run run pulse, then reset in ISSUE");
    applyStimulus(1'b1, 11'd3, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    step(); checkIssue("abort_e1", 16'h11);
    applyStimulus(1'b1, 11'd1, 1'b0);
    step();
    applyStimulus(1'b0, 11'd0, 1'b0);
    checkOutput("abort_e2_addr", 32'(memAddr), 32'd1);
    step(); checkIssue("abort_e3", 16'h22);
    busy = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_start", 32'(start), 32'd0);
    checkOutput("abort_active", 32'(active), 32'd0);
    checkOutput("abort_instr", 32'(instructionOut), 32'd0);
    checkOutput("abort_addr", 32'(memAddr), 32'd0);
    checkOutput("abort_count", cycleCount, 32'd0);
    busy = 1'b0;
    step();
    checkOutput("abort_hold_done", 32'(done), 32'd0);
    reset = 1'b1;
    step();
    checkOutput("abort_idle_done", 32'(done), 32'd0);
    runBasic("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
